// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice plus a carry flop, LSB first, WIDTH clocks per result.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port (a - b - c_in, c_out reports borrow).
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q;
    logic             inv_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q, ovf_q, done_q;
    logic             sum_bit;

    logic [WIDTH-1:0] b_load;
    logic             c_load, inv_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + ~c_in; the final carry is inverted to report a borrow.
    always_comb begin
        b_load   = sub ? ~b : b;
        c_load   = sub ? ~c_in : c_in;
        inv_load = sub;
    end
`else
    always_comb begin
        b_load   = b;
        c_load   = c_in;
        inv_load = 1'b0;
    end
`endif

    always_comb begin
        sum_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        s_sh_d  = {sum_bit, s_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b_load;
                        carry_q <= c_load;
                        inv_q   <= inv_load;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= carry_d;
                    if (cnt_q == LAST) begin
                        // carry_q here is the carry into the MSB slice
                        sum_q   <= s_sh_d;
                        c_out_q <= carry_d ^ inv_q;
                        ovf_q   <= carry_q ^ carry_d;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands against an arithmetic model.
module tb_serial_adder;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, c_out, overflow;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
    function automatic void model(input int ia, input int ib, input int ic, input int is,
                                  output int es, output int ec, output int eo);
        int sa, sb, tot, stot;
        sa = (ia >= M / 2) ? ia - M : ia;
        sb = (ib >= M / 2) ? ib - M : ib;
        if (is != 0) begin
            tot  = ia - ib - ic;
            stot = sa - sb - ic;
            ec   = (tot < 0) ? 1 : 0;
        end else begin
            tot  = ia + ib + ic;
            stot = sa + sb + ic;
            ec   = (tot >= M) ? 1 : 0;
        end
        es = tot & (M - 1);
        eo = (stot > M / 2 - 1 || stot < -(M / 2)) ? 1 : 0;
    endfunction

    task automatic set_ops(input int ia, input int ib, input int ic, input int is);
        a    = W'(ia);
        b    = W'(ib);
        c_in = ic[0];
`ifdef SERIAL_ADDER_SUB_EN
        sub  = is[0];
`else
        if (is != 0) $display("[TB] note: sub requested in add-only build");
`endif
    endtask

    // Returns at the first busy negedge with start already dropped.
    task automatic launch(input int ia, input int ib, input int ic, input int is);
        @(negedge clk);
        set_ops(ia, ib, ic, is);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int nb);
        lat = lat0;
        nb  = lat0 - 1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_values(input string tag, input int ia, input int ib, input int ic, input int is);
        int es, ec, eo;
        model(ia, ib, ic, is, es, ec, eo);
        check({tag, ".done"}, 32'(done), 32'(1));
        check({tag, ".busy_at_done"}, 32'(busy), 32'(0));
        check({tag, ".sum"}, 32'(sum), 32'(es));
        check({tag, ".c_out"}, 32'(c_out), 32'(ec));
        check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    endtask

    task automatic run_op(input string tag, input int ia, input int ib, input int ic, input int is);
        int lat, nb;
        launch(ia, ib, ic, is);
        wait_done(1, lat, nb);
        check({tag, ".latency"}, 32'(lat), 32'(W + 1));
        check({tag, ".busy_cycles"}, 32'(nb), 32'(W));
        check_values(tag, ia, ib, ic, is);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        int lat, nb, ndone, ra, rb, rc, rs;

        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check("reset.busy", 32'(busy), 32'(0));
        check("reset.done", 32'(done), 32'(0));
        check("reset.sum", 32'(sum), 32'(0));
        check("reset.c_out", 32'(c_out), 32'(0));
        check("reset.ovf", 32'(overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1", 5, 2, 0, 0);
        run_op("t2a", 10, 6, 0, 0);
        run_op("t2b", 7, 1, 1, 0);
        run_op("max", 15, 15, 1, 0);
        run_op("neg_ovf", 8, 8, 0, 0);

        // Second start during RUN must be ignored.
        launch(9, 4, 1, 0);
        set_ops(15, 15, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3.sum_stable", 32'(sum), 32'(0));
        wait_done(2, lat, nb);
        check("t3.latency", 32'(lat), 32'(W + 1));
        check_values("t3", 9, 4, 1, 0);
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) ndone++;
        end
        check("t3.no_extra", 32'(ndone), 32'(0));

        // Start presented in the done cycle is accepted immediately.
        launch(6, 5, 0, 0);
        wait_done(1, lat, nb);
        check_values("t4a", 6, 5, 0, 0);
        set_ops(3, 4, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4.busy_after_done", 32'(busy), 32'(1));
        wait_done(1, lat, nb);
        check("t4.gap", 32'(lat), 32'(W + 1));
        check_values("t4b", 3, 4, 0, 0);
        @(negedge clk);

        // Asynchronous reset in the second RUN cycle.
        launch(12, 3, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.busy", 32'(busy), 32'(0));
        check("t5.sum", 32'(sum), 32'(0));
        check("t5.done", 32'(done), 32'(0));
        #9;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("t5.no_done", 32'(ndone), 32'(0));
        run_op("t5.after", 12, 3, 1, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("t6a", 5, 2, 0, 1);
        run_op("t6b", 6, 9, 0, 1);
        run_op("t6c", 10, 4, 1, 1);
        run_op("sub_ovf", 8, 1, 0, 1);
`endif

        for (int i = 0; i < 30; i++) begin
            ra = int'($urandom_range(M - 1, 0));
            rb = int'($urandom_range(M - 1, 0));
            rc = int'($urandom_range(1, 0));
`ifdef SERIAL_ADDER_SUB_EN
            rs = int'($urandom_range(1, 0));
`else
            rs = 0;
`endif
            run_op("rand", ra, rb, rc, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
